// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: CPU-side request/response signals and the byte-wide memory bus
// of mem_ctrl, grouped into one bundle. The slave modport is the controller's
// view; the master modport is the view of the core/memory surrounding it.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  rdy;
  logic                  flush;
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;
  logic                  ls_req;
  logic                  ls_we;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [1:0]            ls_size;
  logic [31:0]           ls_wdata;
  logic                  ls_done;
  logic [31:0]           ls_rdata;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport slave (
    input  rdy, flush, if_req, if_addr, ls_req, ls_we, ls_addr, ls_size,
           ls_wdata, mem_din, io_buffer_full,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy, flush, if_req, if_addr, ls_req, ls_we, ls_addr, ls_size,
           ls_wdata, mem_din, io_buffer_full,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises 32-bit fetches and 1/2/4-byte loads/stores onto a
// single-port byte-wide memory/IO bus. Load/store wins over fetch, results are
// returned with a one-cycle done pulse, and rdy=0 freezes every register.
// Optional feature macro MEM_CTRL_IO_FULL_EN: IO-mapped stores wait in IDLE
// while io_buffer_full is high (fetches may still be accepted meanwhile).
module mem_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h30000)
) (
  input  logic     clk,
  input  logic     rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_a, w_mem_a_nxt;
  logic [7:0]            r_mem_dout, w_mem_dout_nxt;
  logic                  r_mem_wr, w_mem_wr_nxt;
  logic                  r_if_done, w_if_done_nxt;
  logic                  r_ls_done, w_ls_done_nxt;
  logic [31:0]           r_if_data, w_if_data_nxt;
  logic [31:0]           r_ls_rdata, w_ls_rdata_nxt;
  logic [31:0]           r_buf, w_buf_nxt;      // bytes assembled so far
  logic [31:0]           r_wdata, w_wdata_nxt;  // latched store data
  logic [1:0]            r_last, w_last_nxt;    // index of final byte (n-1)
  logic [2:0]            r_cnt, w_cnt_nxt;      // cycles spent in READ/WRITE
  logic                  r_is_fetch, w_is_fetch_nxt;
  logic [31:0]           w_buf_ins;             // r_buf with this cycle's mem_din merged
  logic                  w_is_io;
  logic                  w_io_wait;

  // Byte count minus one; the reserved size code behaves like a word.
  function automatic logic [1:0] size_to_last(input logic [1:0] size);
    case (size)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Little-endian byte lane select.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  assign w_is_io = (bus.ls_addr >= IO_BASE);

`ifdef MEM_CTRL_IO_FULL_EN
  assign w_io_wait = bus.ls_we && w_is_io && bus.io_buffer_full;
`else
  logic w_unused_io;
  assign w_io_wait   = 1'b0;
  assign w_unused_io = ^{bus.io_buffer_full, w_is_io};
`endif

  // Merge the byte arriving now; in READ cycle j (r_cnt=j-1) mem_din holds byte j-2.
  always_comb begin
    w_buf_ins = r_buf;
    case (r_cnt)
      3'd1:    w_buf_ins[7:0]   = bus.mem_din;
      3'd2:    w_buf_ins[15:8]  = bus.mem_din;
      3'd3:    w_buf_ins[23:16] = bus.mem_din;
      3'd4:    w_buf_ins[31:24] = bus.mem_din;
      default: w_buf_ins = r_buf;
    endcase
  end

  // Next-state and next-output logic; everything holds while rdy is low.
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_a_nxt    = r_mem_a;
    w_mem_dout_nxt = r_mem_dout;
    w_mem_wr_nxt   = r_mem_wr;
    w_if_done_nxt  = r_if_done;
    w_ls_done_nxt  = r_ls_done;
    w_if_data_nxt  = r_if_data;
    w_ls_rdata_nxt = r_ls_rdata;
    w_buf_nxt      = r_buf;
    w_wdata_nxt    = r_wdata;
    w_last_nxt     = r_last;
    w_cnt_nxt      = r_cnt;
    w_is_fetch_nxt = r_is_fetch;
    if (bus.rdy) begin
      w_if_done_nxt = 1'b0;
      w_ls_done_nxt = 1'b0;
      w_mem_wr_nxt  = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_if_done || r_ls_done) begin
            // a done pulse is showing: keep at least one idle cycle
            w_state_nxt = S_IDLE;
          end else if (bus.ls_req && !w_io_wait) begin
            w_last_nxt     = size_to_last(bus.ls_size);
            w_wdata_nxt    = bus.ls_wdata;
            w_is_fetch_nxt = 1'b0;
            w_cnt_nxt      = 3'd0;
            w_buf_nxt      = 32'd0;
            w_mem_a_nxt    = bus.ls_addr;
            if (bus.ls_we) begin
              w_mem_dout_nxt = bus.ls_wdata[7:0];
              w_mem_wr_nxt   = 1'b1;
              w_state_nxt    = S_WRITE;
            end else begin
              w_state_nxt = S_READ;
            end
          end else if (bus.if_req && !bus.flush) begin
            w_last_nxt     = 2'd3;
            w_is_fetch_nxt = 1'b1;
            w_cnt_nxt      = 3'd0;
            w_buf_nxt      = 32'd0;
            w_mem_a_nxt    = bus.if_addr;
            w_state_nxt    = S_READ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_READ: begin
          if (r_is_fetch && bus.flush) begin
            // abandoned fetch: partial bytes are simply never published
            w_cnt_nxt   = 3'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
            if (r_cnt < {1'b0, r_last}) begin
              w_mem_a_nxt = r_mem_a + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
              w_mem_a_nxt = r_mem_a;
            end
            if (r_cnt != 3'd0) begin
              w_buf_nxt = w_buf_ins;
            end else begin
              w_buf_nxt = r_buf;
            end
            if (r_cnt == ({1'b0, r_last} + 3'd1)) begin
              w_cnt_nxt   = 3'd0;
              w_state_nxt = S_IDLE;
              if (r_is_fetch) begin
                w_if_data_nxt = w_buf_ins;
                w_if_done_nxt = 1'b1;
              end else begin
                w_ls_rdata_nxt = w_buf_ins;
                w_ls_done_nxt  = 1'b1;
              end
            end else begin
              w_state_nxt = S_READ;
            end
          end
        end
        S_WRITE: begin
          if (r_cnt < {1'b0, r_last}) begin
            w_mem_a_nxt    = r_mem_a + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            w_mem_dout_nxt = pick_byte(r_wdata, r_cnt[1:0] + 2'd1);
            w_mem_wr_nxt   = 1'b1;
            w_cnt_nxt      = r_cnt + 3'd1;
            w_state_nxt    = S_WRITE;
          end else begin
            w_ls_done_nxt = 1'b1;
            w_cnt_nxt     = 3'd0;
            w_state_nxt   = S_IDLE;
          end
        end
        default: begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_if_data  <= 32'd0;
      r_ls_rdata <= 32'd0;
      r_buf      <= 32'd0;
      r_wdata    <= 32'd0;
      r_last     <= 2'd0;
      r_cnt      <= 3'd0;
      r_is_fetch <= 1'b0;
    end else begin
      r_mem_a    <= w_mem_a_nxt;
      r_mem_dout <= w_mem_dout_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
      r_if_done  <= w_if_done_nxt;
      r_ls_done  <= w_ls_done_nxt;
      r_if_data  <= w_if_data_nxt;
      r_ls_rdata <= w_ls_rdata_nxt;
      r_buf      <= w_buf_nxt;
      r_wdata    <= w_wdata_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_is_fetch <= w_is_fetch_nxt;
    end
  end

  assign bus.mem_a    = r_mem_a;
  assign bus.mem_dout = r_mem_dout;
  assign bus.mem_wr   = r_mem_wr;
  assign bus.if_done  = r_if_done;
  assign bus.if_data  = r_if_data;
  assign bus.ls_done  = r_ls_done;
  assign bus.ls_rdata = r_ls_rdata;

endmodule
